seq_booth_mult: RTL and testbench
=================================

SEQ_BOOTH_MULT -- requirements
Module: seq_booth_mult

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning operand width; legal values are even and >= 4.
REQ-002 The block SHALL have parameter RADIX4, default 1, meaning 1 = radix-4 Booth recoding and 0 = radix-2 Booth recoding.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a multiply.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept start this cycle.
REQ-007 The block SHALL have port tc, input, 1 bit: 1 = operands are two's complement, 0 = operands are unsigned; sampled with start.
REQ-008 The block SHALL have port mcand, input, N bits: multiplicand; sampled with start.
REQ-009 The block SHALL have port mplier, input, N bits: multiplier; sampled with start.
REQ-010 The block SHALL have port abort, input, 1 bit: synchronous cancel of the operation in flight.
REQ-011 The block SHALL have port out_valid, output, 1 bit: product holds a valid result.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the product.
REQ-013 The block SHALL have port product, output, 2N bits: the result, registered.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 in IDLE, and 1 in DONE when out_ready=1; it SHALL be 0 otherwise.
REQ-016 Accept: start=1 and in_ready=1 at a rising edge SHALL latch mcand, mplier and tc, clear the accumulator, load the iteration counter and move to RUN.
REQ-017 Operands SHALL be sign-extended (tc=1) or zero-extended (tc=0) internally to N+2 bits, so one datapath serves both modes.
REQ-018 ITER SHALL be N/2+1 when RADIX4=1 and N+1 when RADIX4=0.
REQ-019 In RUN, each edge SHALL perform one Booth step: add 0, +-mcand (or +-2*mcand for radix 4) to the accumulator, then arithmetic right shift by 1 (radix 2) or 2 (radix 4).
REQ-020 The accept edge k SHALL be followed by RUN edges k+1..k+ITER; the edge k+ITER SHALL load product, set out_valid=1 and enter DONE.
REQ-021 product SHALL equal the exact 2N-bit product: signed when tc=1, unsigned when tc=0, with no overflow possible.
REQ-022 In DONE, product and out_valid SHALL hold stable until out_ready=1 at an edge.
REQ-023 DONE with out_ready=1 and start=0 SHALL clear out_valid and move to IDLE; product SHALL keep its last value.
REQ-024 DONE with out_ready=1 and start=1 (back-to-back) SHALL clear out_valid, accept the new operands and enter RUN in the same edge.
REQ-025 start while in_ready=0 SHALL be ignored and not queued.
REQ-026 abort=1 in RUN SHALL return to IDLE at the next edge with out_valid=0; product SHALL be unchanged.
REQ-027 abort SHALL be ignored in IDLE and DONE, and SHALL take priority over start at the same edge.
REQ-028 Operand inputs SHALL not affect an operation after its accept edge.

Reset
REQ-029 reset=0 SHALL immediately force state=IDLE, out_valid=0, product=0, accumulator=0, counter=0 and latched operands=0, independent of clk.
REQ-030 A reset asserted mid-RUN or in DONE SHALL discard the operation; after release the block SHALL be in IDLE with in_ready=1.

Verification
REQ-031 N=8, RADIX4=0, tc=0, mcand=0xFF, mplier=0xFF, out_ready=1 -> out_valid=1 exactly 9 edges after accept, product=0xFE01.
REQ-032 N=8, RADIX4=1, tc=1, mcand=0x80, mplier=0x80 -> out_valid=1 after 5 edges, product=0x4000; tc=1, mcand=0xFF, mplier=0x01 -> product=0xFFFF.
REQ-033 N=8, tc=0, mcand=0x80, mplier=0xFF -> product=0x7F80; same operands with tc=1 -> product=0x0080.
REQ-034 out_ready=0 for 5 cycles in DONE -> product and out_valid stable; then out_ready=1 with start=1 and 3x7 -> next product=21 with no idle cycle between operations.
REQ-035 abort mid-RUN -> IDLE next edge, out_valid=0; start with abort=1 in IDLE -> operation accepted.
REQ-036 reset pulsed mid-RUN -> outputs 0 immediately, in_ready=1 after release; random signed and unsigned operands for N=8,16,32 in both RADIX4 settings -> match a reference model.

Source files
------------

// File: rtl/seq_booth_mult.sv
// Sequential Booth multiplier (radix-2 or radix-4) for signed or unsigned N-bit operands.
// Shares one (N+2)-bit extended datapath between both signedness modes.
module seq_booth_mult #(
    parameter int N      = 32,
    parameter bit RADIX4 = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           in_ready,
    input  logic           tc,
    input  logic [N-1:0]   mcand,
    input  logic [N-1:0]   mplier,
    input  logic           abort,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product
);

    localparam int W    = N + 2;
    localparam int AW   = N + 4;
    localparam int SW   = AW + W + 1;
    localparam int SH   = RADIX4 ? 2 : 1;
    localparam int ITER = RADIX4 ? (N / 2 + 1) : (N + 1);
    localparam int CW   = $clog2(N + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r, state_s;
    logic [AW-1:0]  acc_r, acc_s;
    logic [W-1:0]   mcd_r, mcd_s;
    logic [W-1:0]   mpl_r, mpl_s;
    logic           qm1_r, qm1_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic [2*N-1:0] product_r, product_s;
    logic           out_valid_r, out_valid_s;

    logic           in_ready_s;
    logic           load_s, step_en_s, finish_s, release_s;
    logic [AW-1:0]  mcd_ext_s, pp_s, sum_s;
    logic [SW-1:0]  step_s;
    logic [AW-1:0]  acc_step_s;
    logic [W-1:0]   mpl_step_s;
    logic           qm1_step_s;
    logic [2*N-1:0] prod_step_s;

    // One Booth step: select partial product, add, arithmetic shift, and form the final product view.
    always_comb begin
        mcd_ext_s = {{(AW-W){mcd_r[W-1]}}, mcd_r};
        pp_s      = {AW{1'b0}};
        if (RADIX4) begin
            case ({mpl_r[1:0], qm1_r})
                3'b001, 3'b010: pp_s = mcd_ext_s;
                3'b011:         pp_s = {mcd_ext_s[AW-2:0], 1'b0};
                3'b100:         pp_s = -{mcd_ext_s[AW-2:0], 1'b0};
                3'b101, 3'b110: pp_s = -mcd_ext_s;
                default:        pp_s = {AW{1'b0}};
            endcase
        end else begin
            case ({mpl_r[0], qm1_r})
                2'b01:   pp_s = mcd_ext_s;
                2'b10:   pp_s = -mcd_ext_s;
                default: pp_s = {AW{1'b0}};
            endcase
        end
        sum_s  = acc_r + pp_s;
        step_s = $signed({sum_s, mpl_r, qm1_r}) >>> SH;
        {acc_step_s, mpl_step_s, qm1_step_s} = step_s;
        // After the last step the low product bits have been shifted into the multiplier register.
        if (RADIX4) begin
            prod_step_s = {acc_step_s[N-3:0], mpl_step_s};
        end else begin
            prod_step_s = {acc_step_s[N-2:0], mpl_step_s[W-1:1]};
        end
    end

    // Control FSM: next state and datapath commands.
    always_comb begin
        in_ready_s = (state_r == IDLE) || ((state_r == DONE) && out_ready);
        state_s    = state_r;
        load_s     = 1'b0;
        step_en_s  = 1'b0;
        finish_s   = 1'b0;
        release_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s  = 1'b1;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_s = IDLE;
                end else begin
                    step_en_s = 1'b1;
                    if (cnt_r == CW'(1)) begin
                        finish_s = 1'b1;
                        state_s  = DONE;
                    end else begin
                        state_s = RUN;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    release_s = 1'b1;
                    if (start) begin
                        load_s  = 1'b1;
                        state_s = RUN;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath next values: operand load, Booth iteration, result capture.
    always_comb begin
        acc_s       = acc_r;
        mcd_s       = mcd_r;
        mpl_s       = mpl_r;
        qm1_s       = qm1_r;
        cnt_s       = cnt_r;
        product_s   = product_r;
        out_valid_s = out_valid_r;
        if (load_s) begin
            mcd_s = {{2{tc & mcand[N-1]}}, mcand};
            mpl_s = {{2{tc & mplier[N-1]}}, mplier};
            qm1_s = 1'b0;
            acc_s = {AW{1'b0}};
            cnt_s = CW'(ITER);
        end else if (step_en_s) begin
            acc_s = acc_step_s;
            mpl_s = mpl_step_s;
            qm1_s = qm1_step_s;
            cnt_s = cnt_r - CW'(1);
        end else begin
            cnt_s = cnt_r;
        end
        if (finish_s) begin
            product_s   = prod_step_s;
            out_valid_s = 1'b1;
        end else if (release_s) begin
            out_valid_s = 1'b0;
        end else begin
            out_valid_s = out_valid_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            acc_r       <= {AW{1'b0}};
            mcd_r       <= {W{1'b0}};
            mpl_r       <= {W{1'b0}};
            qm1_r       <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            product_r   <= {(2*N){1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            mcd_r       <= mcd_s;
            mpl_r       <= mpl_s;
            qm1_r       <= qm1_s;
            cnt_r       <= cnt_s;
            product_r   <= product_s;
            out_valid_r <= out_valid_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign product   = product_r;

endmodule

// File: tb/tb_seq_booth_mult.sv
// Bench for seq_booth_mult: six instances (N=8,16,32 x radix-2/radix-4) share one stimulus bus;
// directed vectors target the N=8 instances, random operands are checked on all of them.
module tb_seq_booth_mult;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        tc = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] mcand_b = 32'd0;
    logic [31:0] mplier_b = 32'd0;
    logic [5:0]  ov;
    logic [5:0]  ir;
    logic [63:0] prod [6];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    // Instance g: N = 8/8/16/16/32/32, even g radix-2, odd g radix-4.
    for (genvar g = 0; g < 6; g++) begin : g_dut
        localparam int NV = (g < 2) ? 8 : ((g < 4) ? 16 : 32);
        localparam bit RV = (g % 2 == 1);
        logic [2*NV-1:0] p;
        seq_booth_mult #(.N(NV), .RADIX4(RV)) u_dut (
            .clk(clk), .reset(reset), .start(start), .in_ready(ir[g]), .tc(tc),
            .mcand(mcand_b[NV-1:0]), .mplier(mplier_b[NV-1:0]), .abort(abort),
            .out_valid(ov[g]), .out_ready(out_ready), .product(p)
        );
        assign prod[g] = 64'(p);
    end

    function automatic int width_of(int i);
        return (i < 2) ? 8 : ((i < 4) ? 16 : 32);
    endfunction

    // Exact product from plain integer arithmetic, truncated to 2n bits.
    function automatic logic [63:0] ref_mul(int n, bit s, logic [31:0] a, logic [31:0] b);
        logic [63:0] m, ea, eb, p;
        m  = (64'd1 << n) - 64'd1;
        ea = {32'd0, a} & m;
        eb = {32'd0, b} & m;
        if (s && ea[n-1]) ea = ea | ~m;
        if (s && eb[n-1]) eb = eb | ~m;
        p = ea * eb;
        if (n < 32) p = p & ((64'd1 << (2 * n)) - 64'd1);
        return p;
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        out_ready = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one start, then scramble operand inputs so late sampling would show.
    task automatic issue(bit t, logic [31:0] a, logic [31:0] b);
        @(negedge clk);
        tc = t;
        mcand_b = a;
        mplier_b = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mcand_b = $urandom;
        mplier_b = $urandom;
        tc = ~t;
    endtask

    task automatic wait_valid(int i, output int lat);
        lat = -1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            #1;
            if (ov[i]) begin
                lat = e;
                break;
            end
        end
    endtask

    typedef struct {
        int          inst;
        bit          t;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vt [7];

    initial begin
        int lat;
        bit t;
        logic [31:0] ra, rb;

        vt[0] = '{0, 1'b0, 32'hFF, 32'hFF, 64'hFE01, 9};
        vt[1] = '{1, 1'b1, 32'h80, 32'h80, 64'h4000, 5};
        vt[2] = '{1, 1'b1, 32'hFF, 32'h01, 64'hFFFF, 5};
        vt[3] = '{1, 1'b0, 32'h80, 32'hFF, 64'h7F80, 5};
        vt[4] = '{1, 1'b1, 32'h80, 32'hFF, 64'h0080, 5};
        vt[5] = '{0, 1'b1, 32'h80, 32'h80, 64'h4000, 9};
        vt[6] = '{0, 1'b1, 32'hFF, 32'h01, 64'hFFFF, 9};

        #1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("reset_valid%0d", i), 64'(ov[i]), 64'd0);
            check($sformatf("reset_prod%0d", i), prod[i], 64'd0);
            check($sformatf("reset_ready%0d", i), 64'(ir[i]), 64'd1);
        end
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 7; v++) begin
            settle();
            issue(vt[v].t, vt[v].a, vt[v].b);
            wait_valid(vt[v].inst, lat);
            check($sformatf("vec%0d_latency", v), 64'(lat), 64'(vt[v].lat));
            check($sformatf("vec%0d_product", v), prod[vt[v].inst], vt[v].exp);
        end

        // Hold in DONE, then back-to-back accept of 3x7.
        settle();
        out_ready = 1'b0;
        issue(1'b0, 32'd12, 32'd11);
        wait_valid(1, lat);
        check("hold_latency", 64'(lat), 64'd5);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_valid%0d", c), 64'(ov[1]), 64'd1);
            check($sformatf("hold_prod%0d", c), prod[1], 64'd132);
        end
        @(negedge clk);
        out_ready = 1'b1;
        start = 1'b1;
        tc = 1'b0;
        mcand_b = 32'd3;
        mplier_b = 32'd7;
        #1;
        check("b2b_in_ready", 64'(ir[1]), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_valid_clear", 64'(ov[1]), 64'd0);
        check("b2b_running", 64'(ir[1]), 64'd0);
        wait_valid(1, lat);
        check("b2b_latency", 64'(lat), 64'd5);
        check("b2b_product", prod[1], 64'd21);

        // Abort mid-RUN, then start with abort high in IDLE.
        settle();
        issue(1'b1, 32'h05, 32'h06);
        @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valid", 64'(ov[1]), 64'd0);
        check("abort_idle", 64'(ir[1]), 64'd1);
        check("abort_prod_kept", prod[1], 64'd21);
        @(negedge clk);
        start = 1'b1;
        tc = 1'b0;
        mcand_b = 32'd9;
        mplier_b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_accepted", 64'(ir[1]), 64'd0);
        wait_valid(1, lat);
        check("abort_start_latency", 64'(lat), 64'd5);
        check("abort_start_product", prod[1], 64'd81);

        // Asynchronous reset in the middle of a run.
        settle();
        issue(1'b0, 32'h33, 32'h44);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_prod1", prod[1], 64'd0);
        check("rst_prod5", prod[5], 64'd0);
        check("rst_valid", 64'(ov), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_ready1", 64'(ir[1]), 64'd1);
        check("rst_ready4", 64'(ir[4]), 64'd1);

        for (int r = 0; r < 20; r++) begin
            settle();
            t = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if (r == 0) begin
                ra = 32'hFFFF_FFFF;
                rb = 32'hFFFF_FFFF;
            end
            if (r == 1) begin
                ra = 32'h8000_0000;
                rb = 32'h8000_0000;
            end
            issue(t, ra, rb);
            repeat (40) @(posedge clk);
            #1;
            for (int i = 0; i < 6; i++) begin
                check($sformatf("rand%0d_inst%0d_tc%0d", r, i, t), prod[i],
                      ref_mul(width_of(i), t, ra, rb));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
